seg_display_arbiter: RTL and testbench
======================================

// Module: seg_display_arbiter
// PURPOSE
// - Shares the 4-digit seven-segment display between N_REQ requesters (e.g. PC, ALU result, regfile probe).
// - Each requester offers a 16-bit value. The block grants the display round-robin, with a minimum hold time per owner.
// - It converts the owner's value to 4 hex digit patterns and drives the segs bus of the display scan controller.
// - It sits between the core debug taps and the display scanner; it is the only writer of segs.
// PARAMETERS
// - N_REQ        4            number of requesters, 1..4 (owner id is shown on the decimal points)
// - HOLD_CYCLES  100_000_000  minimum tenure in clk cycles (1 s at 100 MHz); must be >= 1
// - CNT_W        $clog2(HOLD_CYCLES+1)  hold counter width (derived; not overridden)
// PORTS
// - clk     in   1             system clock, 100 MHz
// - rst_n   in   1             synchronous reset, active-low
// - req     in   N_REQ         req[i]=1: requester i wants the display; level, held while wanted
// - data    in   N_REQ x 16    data[i]: value to show for requester i; sampled live while i owns the display
// - grant   out  N_REQ         one-hot current owner; all-zero when idle
// - busy    out  1             1 while any requester owns the display
// - owner   out  2             index of current or most recent owner
// - segs    out  4 x 8         segs[d] is the pattern for digit d (d=0 rightmost); bit7=DP, bits6:0=g..a; active-low
// BEHAVIOUR
// - Reset (rst_n=0 at posedge clk)
//   - grant=0, busy=0, owner=0, segs[0..3]=8'hFF (blank).
//   - Internal last pointer = N_REQ-1, so requester 0 wins first.
//   - hold counter = 0; state = IDLE.
// - States: IDLE, SHOW. All outputs are registered.
// - IDLE
//   - segs blank, grant=0.
//   - If req!=0, pick the winner: first set bit searching upward from last+1, mod N_REQ.
//   - On the same edge: state=SHOW, owner=winner, grant=onehot(winner), busy=1.
//   - Also on that edge: last=winner, counter=HOLD_CYCLES-1, segs=encode(data[winner]).
//   - Latency: req high at edge k produces grant and segs valid after edge k+1.
// - SHOW
//   - Each cycle, segs=encode(data[owner]): 1-cycle latency from data to segs.
//   - counter decrements while nonzero.
// - SHOW termination, evaluated each edge in priority order:
//   - (a) req[owner]=0: tenure ends immediately, regardless of counter.
//     - If other reqs are pending, re-arbitrate on this edge; otherwise go IDLE and blank segs.
//   - (b) counter==0 and req[owner]=1:
//     - If other reqs are pending, re-arbitrate on this edge; the new owner is never the old one.
//     - If the owner is the only requester, it keeps the display; counter reloads to HOLD_CYCLES-1; grant stays high with no gap.
//   - (c) otherwise hold; new requests wait, and no preemption occurs before counter==0.
// - A handover is a single edge: grant moves one-hot to one-hot and is never zero between owners.
// - Encoding
//   - Digit d shows nibble data[4d+3:4d] as hex 0-F, using active-low patterns:
//     - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
//     - 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E
//   - The DP of digit owner is lit (bit7=0); all other DPs are off.
// - Width rules: the round-robin search wraps mod N_REQ. Bits of req beyond N_REQ do not exist. owner is zero-extended to 2 bits.
// - Reset mid-tenure: everything returns to reset values on that edge; there is no partial handover.
// STRUCTURE
// - Package seg_pkg:
//   - typedef logic [7:0] seg_t; typedef seg_t [3:0] segs_t.
//   - constant SEG_BLANK=8'hFF.
//   - function hex_to_seg(logic [3:0]) -> logic [6:0], holding the table above.
//   - enum {IDLE,SHOW} arb_state_t.
// - Sub-module rr_pick: combinational round-robin picker.
//   - Inputs: req, last, exclude_en, exclude_idx.
//   - Outputs: found, idx.
// - Top level: FSM, hold counter, output registers, 4x hex_to_seg.
// TESTING (bench overrides HOLD_CYCLES=4, N_REQ=4)
// - Reset: rst_n=0 for 2 cycles -> segs all 8'hFF, grant=0, busy=0, owner=0.
// - Single requester: req=0001, data[0]=16'h1234, one edge later ->
//   - grant=0001, busy=1.
//   - segs[3..0] = F9,A4,B0,19 (DP lit on digit 0).
//   - Change data[0] to 16'hABCD -> segs = 88,83,C6,21 on the next edge.
// - Rotation: req=1011 held, start from reset ->
//   - owners 0,1,3,0, ... with each tenure exactly 4 cycles.
//   - grant is never 0 between owners.
// - Sole owner: req=0100 held 20 cycles -> grant=0100 throughout, counter reloads, no gap.
//   - Drop req -> next edge grant=0, busy=0, segs=FF.
// - Early release: owner 1 drops req 1 cycle into tenure while req[2]=1 -> next edge grant=0100.
//   - Late requester: req[3] raised mid-tenure of owner 2 -> waits until owner 2's counter reaches 0.
// - Reset mid-tenure: rst_n=0 while owner=2 -> next edge all reset values.
//   - Then req=1111 -> requester 0 wins first.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared segment types, blank constant, hex glyph table and arbiter states
package seg_pkg;
  typedef logic [7:0] seg_t;
  typedef seg_t [3:0] segs_t;
  localparam seg_t SEG_BLANK = 8'hFF;
  typedef enum logic {IDLE, SHOW} arb_state_t;
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    return SEG_LUT[n];
  endfunction
endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search upward from last+1, optionally skipping one index
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       last,
  input  logic             exclude_en,
  input  logic [1:0]       exclude_idx,
  output logic             found,
  output logic [1:0]       idx
);
  logic [3:0] req_x;
  logic [1:0] c;
  assign req_x = 4'(req);
  always_comb begin
    found = 1'b0;
    idx = '0;
    c = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      c = 2'((int'(last) + k) % N_REQ);
      if (!found && req_x[c] && !(exclude_en && c == exclude_idx)) begin
        found = 1'b1;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner of the 4-digit display with minimum hold, hex-encoded segs
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int HOLD_CYCLES = 100_000_000,
  localparam int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0][15:0] data,
  output logic [N_REQ-1:0]      grant,
  output logic                  busy,
  output logic [1:0]            owner,
  output segs_t                 segs
);
  arb_state_t state_q, state_d;
  logic [1:0] owner_q, owner_d, last_q, last_d, pick;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  segs_t segs_q, segs_d;
  logic [3:0] req_x;
  logic [3:0][15:0] data_x;
  logic found, show, own_req, take, keep;
  function automatic segs_t encode(input logic [15:0] v, input logic [1:0] dp);
    segs_t r;
    for (int d = 0; d < 4; d++) r[d] = {2'(d) != dp, hex_to_seg(v[4*d +: 4])};
    return r;
  endfunction
  assign req_x  = 4'(req);
  assign data_x = 64'(data);
  assign show   = state_q == SHOW;
  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (req),
    .last       (last_q),
    .exclude_en (show),
    .exclude_idx(owner_q),
    .found      (found),
    .idx        (pick)
  );
  always_comb begin
    own_req = req_x[owner_q];
    take    = found && (!show || !own_req || cnt_q == '0);
    keep    = show && own_req;
    state_d = take || keep ? SHOW : IDLE;
    owner_d = take ? pick : owner_q;
    last_d  = take ? pick : last_q;
    cnt_d   = take || cnt_q == '0 ? CNT_W'(HOLD_CYCLES - 1) : cnt_q - 1'b1;
    grant_d = take || keep ? N_REQ'(1) << owner_d : '0;
    segs_d  = take || keep ? encode(data_x[owner_d], owner_d) : {4{SEG_BLANK}};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= 2'(N_REQ - 1);
      cnt_q   <= '0;
      grant_q <= '0;
      segs_q  <= {4{SEG_BLANK}};
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      segs_q  <= segs_d;
    end
  end
  assign grant = grant_q;
  assign busy  = show;
  assign owner = owner_q;
  assign segs  = segs_q;
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: directed scenarios plus random traffic against a tenure-age reference model
module tb_seg_display_arbiter;
  localparam int HOLD = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req;
  logic [3:0][15:0] data;
  logic [3:0] grant;
  logic busy;
  logic [1:0] owner;
  logic [3:0][7:0] segs;
  int n_cmp = 0;
  int n_bad = 0;
  logic m_busy;
  logic [1:0] m_owner;
  logic [3:0] m_grant;
  logic [3:0][7:0] m_segs;
  int m_last, m_age;
  seg_display_arbiter #(.N_REQ(4), .HOLD_CYCLES(HOLD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .data (data),
    .grant(grant),
    .busy (busy),
    .owner(owner),
    .segs (segs)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] hx(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction
  function automatic logic [3:0][7:0] enc(input logic [15:0] v, input int dp);
    logic [3:0][7:0] r;
    for (int d = 0; d < 4; d++) r[d] = hx(v[4*d +: 4]) & (d == dp ? 8'h7F : 8'hFF);
    return r;
  endfunction
  // model tracks how many cycles the owner has been shown; tenure may end once that reaches HOLD
  task automatic step();
    int w, c, nl, na;
    logic nb;
    logic [1:0] no;
    logic [3:0] ng;
    logic [3:0][7:0] ns;
    bit rel;
    w = -1;
    if (!rst_n) begin
      nb = 0; no = 0; nl = 3; na = 0; ns = {4{8'hFF}}; ng = 0;
    end else begin
      rel = !m_busy || !req[m_owner] || m_age >= HOLD;
      if (rel)
        for (int k = 1; k <= 4; k++) begin
          c = (m_last + k) % 4;
          if (w < 0 && req[c] && !(m_busy && c == int'(m_owner))) w = c;
        end
      nl = m_last; no = m_owner;
      if (w >= 0) begin
        nb = 1; no = 2'(w); nl = w; na = 1; ns = enc(data[w], w); ng = 4'b1 << w;
      end else if (m_busy && req[m_owner]) begin
        nb = 1; na = m_age >= HOLD ? 1 : m_age + 1; ns = enc(data[m_owner], int'(m_owner)); ng = 4'b1 << m_owner;
      end else begin
        nb = 0; na = 0; ns = {4{8'hFF}}; ng = 0;
      end
    end
    @(posedge clk);
    #1;
    m_busy = nb; m_owner = no; m_last = nl; m_age = na; m_segs = ns; m_grant = ng;
  endtask
  task automatic test_reset();
    rst_n = 0; req = 0; data = '0;
    step(); step();
    n_cmp++;
    if (segs !== {4{8'hFF}}) begin n_bad++; $display("FAIL reset_segs got %h want %h", segs, {4{8'hFF}}); end
    n_cmp++;
    if ({grant, busy, owner} !== 7'b0) begin n_bad++; $display("FAIL reset_ctl got %b want 0000000", {grant, busy, owner}); end
    rst_n = 1;
  endtask
  task automatic test_single();
    req = 4'b0001; data[0] = 16'h1234;
    step();
    n_cmp++;
    if ({grant, busy} !== 5'b00011) begin n_bad++; $display("FAIL single_grant got %b want 00011", {grant, busy}); end
    n_cmp++;
    if (segs !== {8'hF9, 8'hA4, 8'hB0, 8'h19}) begin n_bad++; $display("FAIL single_segs got %h want f9a4b019", segs); end
    data[0] = 16'hABCD;
    step();
    n_cmp++;
    if (segs !== {8'h88, 8'h83, 8'hC6, 8'h21}) begin n_bad++; $display("FAIL single_live got %h want 8883c621", segs); end
    req = 0;
    step();
    n_cmp++;
    if ({grant, busy, segs} !== {4'b0, 1'b0, m_segs}) begin n_bad++; $display("FAIL single_idle got %b/%b/%h want 0/0/%h", grant, busy, segs, m_segs); end
  endtask
  task automatic test_rotation();
    int seq[$], len[$];
    int exp_seq[4] = '{0, 1, 3, 0};
    rst_n = 0; step(); rst_n = 1;
    req = 4'b1011;
    for (int i = 0; i < 26; i++) begin
      step();
      n_cmp++;
      if ({grant, busy, owner} !== {m_grant, m_busy, m_owner}) begin n_bad++; $display("FAIL rot_state got %b want %b", {grant, busy, owner}, {m_grant, m_busy, m_owner}); end
      n_cmp++;
      if (grant === 4'b0) begin n_bad++; $display("FAIL rot_gap cycle %0d got grant 0 want nonzero", i); end
      if (seq.size() == 0 || seq[$] != int'(owner)) begin seq.push_back(int'(owner)); len.push_back(1); end
      else len[$] = len[$] + 1;
    end
    n_cmp++;
    if (seq.size() < 4) begin n_bad++; $display("FAIL rot_count got %0d tenures want >=4", seq.size()); end
    else
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (seq[i] != exp_seq[i]) begin n_bad++; $display("FAIL rot_order[%0d] got %0d want %0d", i, seq[i], exp_seq[i]); end
        if (i < 3) begin
          n_cmp++;
          if (len[i] != HOLD) begin n_bad++; $display("FAIL rot_len[%0d] got %0d want %0d", i, len[i], HOLD); end
        end
      end
  endtask
  task automatic test_sole_owner();
    req = 4'b0100;
    step();
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if (grant !== 4'b0100) begin n_bad++; $display("FAIL sole_grant cycle %0d got %b want 0100", i, grant); end
      n_cmp++;
      if (segs !== m_segs) begin n_bad++; $display("FAIL sole_segs got %h want %h", segs, m_segs); end
    end
    req = 0;
    step();
    n_cmp++;
    if ({grant, busy, segs} !== {4'b0, 1'b0, {4{8'hFF}}}) begin n_bad++; $display("FAIL sole_drop got %b/%b/%h want 0/0/ffffffff", grant, busy, segs); end
  endtask
  task automatic test_early_release();
    logic [3:0] want;
    req = 4'b0010; step();
    n_cmp++;
    if (grant !== 4'b0010) begin n_bad++; $display("FAIL early_first got %b want 0010", grant); end
    req = 4'b0110; step();
    req = 4'b0100; step();
    n_cmp++;
    if (grant !== 4'b0100) begin n_bad++; $display("FAIL early_release got %b want 0100", grant); end
    req = 4'b1100;
    for (int i = 1; i <= 4; i++) begin
      step();
      want = i < 4 ? 4'b0100 : 4'b1000;
      n_cmp++;
      if (grant !== want) begin n_bad++; $display("FAIL late_wait step %0d got %b want %b", i, grant, want); end
      n_cmp++;
      if (segs !== m_segs) begin n_bad++; $display("FAIL late_segs got %h want %h", segs, m_segs); end
    end
  endtask
  task automatic test_reset_mid();
    req = 4'b0100; step();
    n_cmp++;
    if (owner !== 2'd2) begin n_bad++; $display("FAIL mid_owner got %0d want 2", owner); end
    rst_n = 0; step();
    n_cmp++;
    if ({grant, busy, owner, segs} !== {7'b0, {4{8'hFF}}}) begin n_bad++; $display("FAIL mid_reset got %b/%b/%0d/%h want reset values", grant, busy, owner, segs); end
    rst_n = 1; req = 4'b1111; step();
    n_cmp++;
    if (grant !== 4'b0001) begin n_bad++; $display("FAIL mid_restart got %b want 0001", grant); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      data = {$urandom, $urandom};
      rst_n = $urandom_range(0, 99) != 0;
      step();
      n_cmp++;
      if ({grant, busy, owner} !== {m_grant, m_busy, m_owner}) begin n_bad++; $display("FAIL rand_state cycle %0d got %b want %b", i, {grant, busy, owner}, {m_grant, m_busy, m_owner}); end
      n_cmp++;
      if (segs !== m_segs) begin n_bad++; $display("FAIL rand_segs cycle %0d got %h want %h", i, segs, m_segs); end
    end
    rst_n = 1;
  endtask
  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_sole_owner();
    test_early_release();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
